// File: rtl/dff_delay_line_if.sv
// rtl/dff_delay_line_if.sv - signal bundle for the dff_delay_line pipeline
//
// Purpose: groups the pipeline control, data, occupancy and tap signals so a
//   producer/observer (master) and the delay line (slave) connect with one port.
// Parameters:
//   WIDTH  data bits per stage
//   DEPTH  number of pipeline stages (sets count and tap_sel widths)
// Signals (direction seen from the slave):
//   en, flush            in   advance / clear-valid controls
//   din, din_valid       in   input word and its valid bit
//   dout, dout_valid     out  last-stage word and valid bit
//   count                out  number of valid stages
//   tap_sel              in   stage index for the tap
//   tap_data, tap_valid  out  tapped stage word and valid bit
//   par_inj, par_err     in/out  only when DFF_DELAY_PARITY_EN is defined
interface dff_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CW-1:0]    count;
  logic [TW-1:0]    tap_sel;
  logic [WIDTH-1:0] tap_data;
  logic             tap_valid;
`ifdef DFF_DELAY_PARITY_EN
  logic             par_inj;
  logic             par_err;

  modport master (
    output en, flush, din, din_valid, tap_sel, par_inj,
    input  dout, dout_valid, count, tap_data, tap_valid, par_err
  );
  modport slave (
    input  en, flush, din, din_valid, tap_sel, par_inj,
    output dout, dout_valid, count, tap_data, tap_valid, par_err
  );
`else
  modport master (
    output en, flush, din, din_valid, tap_sel,
    input  dout, dout_valid, count, tap_data, tap_valid
  );
  modport slave (
    input  en, flush, din, din_valid, tap_sel,
    output dout, dout_valid, count, tap_data, tap_valid
  );
`endif
endinterface

// File: rtl/dff_delay_line.sv
// rtl/dff_delay_line.sv - multi-bit DFF delay line with valid, stall, flush, count and tap
//
// Purpose: delays WIDTH-bit words by DEPTH enabled clocks, carrying a valid bit
//   per stage. en=0 stalls every register; flush clears valid bits and count but
//   leaves data registers untouched. count tracks how many stages hold valid data.
//   A combinational tap reads any stage selected by tap_sel.
// Optional feature: define DFF_DELAY_PARITY_EN to store an even-parity bit per
//   stage and raise a sticky par_err when a valid word leaves with bad parity.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   io     dff_delay_line_if.slave (en, flush, din, din_valid, dout, dout_valid,
//          count, tap_sel, tap_data, tap_valid [, par_inj, par_err])
module dff_delay_line #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               rst_n,
  dff_delay_line_if.slave   io
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("dff_delay_line: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("dff_delay_line: WIDTH must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] v;
  logic [CW-1:0]    count;

  // Data path: data only moves on enabled, non-flush edges. Flush intentionally
  // leaves the data registers alone; only the valid bits are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage[k] <= RESET_VAL;
      end
    end else if (io.en && !io.flush) begin
      stage[0] <= io.din;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  // Valid bits and occupancy. count moves by +1 on entry, -1 on exit and stays
  // put when one word enters as another leaves, so it always matches the
  // popcount of v and cannot overflow or underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      count <= '0;
    end else if (io.flush) begin
      v     <= '0;
      count <= '0;
    end else if (io.en) begin
      v[0] <= io.din_valid;
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
      end
      case ({io.din_valid, v[DEPTH-1]})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign io.dout       = stage[DEPTH-1];
  assign io.dout_valid = v[DEPTH-1];
  assign io.count      = count;

  // Tap: out-of-range selections read as an empty, invalid stage.
  logic [WIDTH-1:0] tap_data_c;
  logic             tap_valid_c;

  always_comb begin
    tap_data_c  = '0;
    tap_valid_c = 1'b0;
    if (int'(io.tap_sel) < DEPTH) begin
      tap_data_c  = stage[io.tap_sel];
      tap_valid_c = v[io.tap_sel];
    end
  end

  assign io.tap_data  = tap_data_c;
  assign io.tap_valid = tap_valid_c;

`ifdef DFF_DELAY_PARITY_EN
  // Parity bit travels alongside its data word; par_inj corrupts it on entry so
  // the checker at the output can be exercised.
  logic [DEPTH-1:0] p;
  logic             par_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (io.en && !io.flush) begin
      p[0] <= (^io.din) ^ io.par_inj;
      for (int k = 1; k < DEPTH; k++) begin
        p[k] <= p[k-1];
      end
    end
  end

  // Sticky error: checked every edge against the registered output, so it
  // rises one edge after a bad word becomes visible and holds through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (io.flush) begin
      par_err <= 1'b0;
    end else if (v[DEPTH-1] && ((^stage[DEPTH-1]) != p[DEPTH-1])) begin
      par_err <= 1'b1;
    end
  end

  assign io.par_err = par_err;
`endif

endmodule

// File: tb/tb_dff_delay_line.sv
// tb/tb_dff_delay_line.sv - self-checking bench for dff_delay_line (DEPTH 4 and 5)
module tb_dff_delay_line;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dff_delay_line_if #(.WIDTH(8), .DEPTH(4)) i4 ();
  dff_delay_line_if #(.WIDTH(8), .DEPTH(5)) i5 ();

  dff_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u4 (
    .clk(clk), .rst_n(rst_n), .io(i4.slave)
  );
  dff_delay_line #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h00)) u5 (
    .clk(clk), .rst_n(rst_n), .io(i5.slave)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb [$];
  logic [3:0] mv;
  logic [7:0] exp_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic f, input logic [7:0] d, input logic dv);
    i4.en = e; i4.flush = f; i4.din = d; i4.din_valid = dv;
    i5.en = e; i5.flush = f; i5.din = d; i5.din_valid = dv;
  endtask

  // One clock: drive, update the valid model and scoreboard at the edge, check 1 unit later.
  task automatic step(input logic e, input logic f, input logic [7:0] d, input logic dv);
    drive(e, f, d, dv);
    @(posedge clk);
    if (f) begin
      mv = '0;
      sb.delete();
    end else if (e) begin
      mv = {mv[2:0], dv};
      if (dv) sb.push_back(d);
      if (mv[3]) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow observed=empty expected=word");
        end else begin
          exp_dout = sb.pop_front();
        end
      end
    end
    #1;
    chk("dout_valid", 32'(i4.dout_valid), 32'(mv[3]));
    chk("count", 32'(i4.count), 32'($countones(mv)));
    if (mv[3]) chk("dout", 32'(i4.dout), 32'(exp_dout));
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    i4.tap_sel = '0;
    i5.tap_sel = '0;
`ifdef DFF_DELAY_PARITY_EN
    i4.par_inj = 1'b0;
    i5.par_inj = 1'b0;
`endif
    mv = '0;
    exp_dout = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(i4.dout), 32'h00);
    chk("rst_dout_valid", 32'(i4.dout_valid), 32'h0);
    chk("rst_count", 32'(i4.count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream takes effect before the next edge
    step(1'b1, 1'b0, 8'h11, 1'b1);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    step(1'b1, 1'b0, 8'h33, 1'b1);
    chk("pre_rst_count", 32'(i4.count), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(i4.dout), 32'h00);
    chk("async_rst_valid", 32'(i4.dout_valid), 32'h0);
    chk("async_rst_count", 32'(i4.count), 32'h0);
    mv = '0;
    sb.delete();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream A1,B2,C3: counts 1,2,3,3,2,1,0
    step(1'b1, 1'b0, 8'hA1, 1'b1);
    step(1'b1, 1'b0, 8'hB2, 1'b1);
    step(1'b1, 1'b0, 8'hC3, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("stream_a1_out", 32'(i4.dout), 32'hA1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("stream_b2_out", 32'(i4.dout), 32'hB2);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("stream_c3_out", 32'(i4.dout), 32'hC3);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("stream_empty_count", 32'(i4.count), 32'h0);

    // Stall with FF valid on the input: nothing moves, FF never enters
    step(1'b1, 1'b0, 8'h5C, 1'b1);
    step(1'b1, 1'b0, 8'h6D, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'hFF, 1'b1);
      chk("stall_count", 32'(i4.count), 32'h2);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    // Flush with en=1 and din_valid=1 discards everything including the new word
    step(1'b1, 1'b0, 8'h31, 1'b1);
    step(1'b1, 1'b0, 8'h32, 1'b1);
    step(1'b1, 1'b0, 8'h33, 1'b1);
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("flush_count", 32'(i4.count), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    // Tap
    step(1'b1, 1'b0, 8'hA1, 1'b1);
    step(1'b1, 1'b0, 8'hB2, 1'b1);
    step(1'b1, 1'b0, 8'hC3, 1'b1);
    i4.tap_sel = 2'd2;
    #1;
    chk("tap2_data", 32'(i4.tap_data), 32'hA1);
    chk("tap2_valid", 32'(i4.tap_valid), 32'h1);
    i4.tap_sel = 2'd0;
    #1;
    chk("tap0_data", 32'(i4.tap_data), 32'hC3);
    chk("tap0_valid", 32'(i4.tap_valid), 32'h1);
    i4.tap_sel = 2'd3;
    #1;
    chk("tap3_valid", 32'(i4.tap_valid), 32'h0);
    i5.tap_sel = 3'd1;
    #1;
    chk("d5_tap1_data", 32'(i5.tap_data), 32'hB2);
    chk("d5_tap1_valid", 32'(i5.tap_valid), 32'h1);
    i5.tap_sel = 3'd7;
    #1;
    chk("d5_tap7_data", 32'(i5.tap_data), 32'h00);
    chk("d5_tap7_valid", 32'(i5.tap_valid), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

`ifdef DFF_DELAY_PARITY_EN
    // Corrupted parity on 5A is flagged one edge after it reaches dout
    step(1'b1, 1'b1, 8'h00, 1'b0);
    i4.par_inj = 1'b1;
    step(1'b1, 1'b0, 8'h5A, 1'b1);
    i4.par_inj = 1'b0;
    chk("par_err_early", 32'(i4.par_err), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("par_err_before", 32'(i4.par_err), 32'h0);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("par_err_set", 32'(i4.par_err), 32'h1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("par_err_held", 32'(i4.par_err), 32'h1);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    chk("par_err_flush", 32'(i4.par_err), 32'h0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
